demux_14: RTL and testbench

DEMUX_14 -- requirements
Module: demux_14

---
 rtl/demux_14.sv | 89 ++++++++
 tb/tb_demux_14.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_14.sv
// Round-robin 1-to-4 demultiplexer: each accepted word is registered onto the
// next lane in turn, with a one-cycle valid pulse on that lane.
module demux_14 #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_0,
    output logic [DATA_WIDTH-1:0] data_1,
    output logic [DATA_WIDTH-1:0] data_2,
    output logic [DATA_WIDTH-1:0] data_3,
    output logic                  valid_0,
    output logic                  valid_1,
    output logic                  valid_2,
    output logic                  valid_3,
    output logic [1:0]            sel_out,
    output logic [7:0]            word_cnt
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                  state, state_nxt;
    logic [1:0]              ptr;
    logic [1:0]              lane_p0;
    logic [DATA_WIDTH-1:0]   lane_data_p1 [4];
    logic [3:0]              vld_p1;
    logic [7:0]              cnt;

    // flush overrides the pointer for the word arriving in the same cycle
    assign lane_p0 = flush ? 2'd0 : ptr;

    // ---- stage p0 -> p1: steer the accepted word into its lane register ----
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr    <= 2'd0;
            cnt    <= 8'd0;
            vld_p1 <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                lane_data_p1[k] <= '0;
            end
        end else begin
            vld_p1 <= 4'b0000;
            if (valid_in) begin
                lane_data_p1[lane_p0] <= data_in;
                vld_p1[lane_p0]       <= 1'b1;
                ptr                   <= lane_p0 + 2'd1;
                cnt                   <= cnt + 8'd1;
            end else if (flush) begin
                ptr <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Activity tracker; observational only, never feeds the datapath
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in)  state_nxt = ACTIVE;
            ACTIVE:  if (!valid_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign data_0   = lane_data_p1[0];
    assign data_1   = lane_data_p1[1];
    assign data_2   = lane_data_p1[2];
    assign data_3   = lane_data_p1[3];
    assign valid_0  = vld_p1[0];
    assign valid_1  = vld_p1[1];
    assign valid_2  = vld_p1[2];
    assign valid_3  = vld_p1[3];
    assign sel_out  = ptr;
    assign word_cnt = cnt;

endmodule

// File: tb/tb_demux_14.sv
// Randomized and directed bench for demux_14 against a lane/counter model.
module tb_demux_14;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       valid_in = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic [1:0] sel_out;
    logic [7:0] word_cnt;

    int errs = 0;
    int checks = 0;

    demux_14 #(.DATA_WIDTH(4)) dut (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .flush(flush),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .sel_out(sel_out), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    logic [3:0] d_out [4];
    logic [3:0] v_out;
    assign d_out[0] = data_0;
    assign d_out[1] = data_1;
    assign d_out[2] = data_2;
    assign d_out[3] = data_3;
    assign v_out = {valid_3, valid_2, valid_1, valid_0};

    // Reference model state
    int m_data [4];
    int m_valid [4];
    int m_ptr;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_data[k]  = 0;
            m_valid[k] = 0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input int din, input bit vin, input bit fl);
        int lane;
        for (int k = 0; k < 4; k++) m_valid[k] = 0;
        if (vin) begin
            lane          = fl ? 0 : m_ptr;
            m_data[lane]  = din;
            m_valid[lane] = 1;
            m_ptr         = (lane + 1) % 4;
            m_cnt         = (m_cnt + 1) % 256;
        end else if (fl) begin
            m_ptr = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.data_%0d", tag, k), 32'(d_out[k]), 32'(m_data[k]));
            chk($sformatf("%s.valid_%0d", tag, k), 32'(v_out[k]), 32'(m_valid[k]));
        end
        chk({tag, ".sel_out"}, 32'(sel_out), 32'(m_ptr));
        chk({tag, ".word_cnt"}, 32'(word_cnt), 32'(m_cnt));
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic step(input logic [3:0] din, input logic vin, input logic fl);
        data_in  = din;
        valid_in = vin;
        flush    = fl;
        @(posedge clk);
        model_edge(int'(din), vin, fl);
        #1 compare_all("step");
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        flush    = 1'b0;
        reset_L  = 1'b0;
        model_reset();
        #1 compare_all("reset");
        repeat (2) @(negedge clk);
        #2 reset_L = 1'b1;
    endtask

    // Continuous: one-hot valids, unselected lanes hold, pulse counting
    logic [3:0] prev_d [4];
    bit         prev_ok = 0;
    int         pulses [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (reset_L) begin
            chk("onehot_valid", 32'($countones(v_out) <= 1), 32'd1);
            for (int k = 0; k < 4; k++) begin
                if (v_out[k]) pulses[k] = pulses[k] + 1;
                else if (prev_ok) chk($sformatf("hold_lane_%0d", k), 32'(d_out[k]), 32'(prev_d[k]));
            end
        end
        for (int k = 0; k < 4; k++) prev_d[k] = d_out[k];
        prev_ok = reset_L;
    end

    initial begin
        int base [4];
        model_reset();
        @(negedge clk);

        // Four-word burst fills lanes in order
        do_reset();
        step(4'hA, 1, 0);
        step(4'h5, 1, 0);
        step(4'hF, 1, 0);
        step(4'h0, 1, 0);
        chk("burst.lane0", 32'(data_0), 32'hA);
        chk("burst.lane1", 32'(data_1), 32'h5);
        chk("burst.lane2", 32'(data_2), 32'hF);
        chk("burst.lane3", 32'(data_3), 32'h0);
        chk("burst.sel", 32'(sel_out), 32'd0);
        chk("burst.cnt", 32'(word_cnt), 32'd4);

        // Alternating valid
        do_reset();
        step(4'h3, 1, 0);
        step(4'(($urandom)), 0, 0);
        step(4'h7, 1, 0);
        step(4'(($urandom)), 0, 0);
        chk("alt.lane0", 32'(data_0), 32'h3);
        chk("alt.lane1", 32'(data_1), 32'h7);
        chk("alt.lane2", 32'(data_2), 32'h0);
        chk("alt.lane3", 32'(data_3), 32'h0);
        chk("alt.valid", 32'(v_out), 32'h0);

        // Flush with a word forces lane 0
        do_reset();
        step(4'h1, 1, 0);
        step(4'h2, 1, 0);
        chk("flush.pre_sel", 32'(sel_out), 32'd2);
        step(4'h9, 1, 1);
        chk("flush.data0", 32'(data_0), 32'h9);
        chk("flush.valid0", 32'(valid_0), 32'd1);
        chk("flush.sel", 32'(sel_out), 32'd1);
        chk("flush.cnt", 32'(word_cnt), 32'd3);
        step(4'h0, 0, 1);
        chk("flush_idle.sel", 32'(sel_out), 32'd0);
        chk("flush_idle.cnt", 32'(word_cnt), 32'd3);

        // Asynchronous reset between edges during a burst
        step(4'h4, 1, 0);
        step(4'h6, 1, 0);
        data_in  = 4'hB;
        valid_in = 1'b1;
        @(posedge clk);
        #3 reset_L = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        #2 reset_L = 1'b1;
        @(negedge clk);
        step(4'hC, 1, 0);
        chk("after_rst.lane0", 32'(data_0), 32'hC);
        chk("after_rst.valid0", 32'(valid_0), 32'd1);

        // 260 words: counter wraps, each lane pulses 65 times
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) base[k] = pulses[k];
        for (int i = 0; i < 260; i++) step(4'($urandom), 1, 0);
        step(4'h0, 0, 0);
        chk("wrap.cnt", 32'(word_cnt), 32'd4);
        chk("wrap.sel", 32'(sel_out), 32'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrap.pulses_%0d", k), 32'(pulses[k] - base[k]), 32'd65);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++)
            step(4'($urandom), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 7) == 0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
